oc_flash_ctrl: RTL and testbench

- Parametrised Avalon-MM controller placed in front of the on-chip flash macro (data port plus CSR port).
- Passes host burst reads straight through to the flash.
- Turns each host write into a full program sequence: unprotect, program, poll status, reprotect.
- Adds a sector-erase engine with status polling, timeout and error reporting, so software never touches the flash CSR directly.

---
 rtl/oc_flash_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_oc_flash_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oc_flash_ctrl.sv
// oc_flash_ctrl
// Avalon-MM front end for the on-chip flash macro. Host reads go straight
// through to the flash data port. Each host write becomes a full program
// sequence: unprotect, program, poll status, reprotect. A sector-erase engine
// does the same with status polling, a timeout and error reporting.
//
// Ports
//   clock, reset_n            system clock, async active-low reset
//   avs_*                     host slave port (burst reads, single-beat writes)
//   erase_req, erase_sector   one-cycle erase request for sector 1..5
//   op_busy, op_done, op_err  sequence status; op_err is valid with op_done
//   flash_data_*              master port to the flash data interface
//   flash_csr_*               master port to the flash CSR (0=status, 1=control)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | read pass-through; start a sequence once no read beats are owed
// S_UNLOCK | write CTRL_UNLOCK to the control register
// S_PROG   | hold flash_data_write until the flash accepts the word
// S_ERASE  | write CTRL_UNLOCK with the sector number in [22:20]
// S_POLL   | read status every 2 cycles until busy was seen and then cleared
// S_CHECK  | turn the captured ok bit into the error flag
// S_LOCK   | write CTRL_LOCK to restore full write protection
// S_DONE   | op_done pulse; releases a host write for one cycle
module oc_flash_ctrl #(
  parameter int          ADDR_W      = 16,
  parameter int          BURST_W     = 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12000000,
  parameter logic [31:0] CTRL_LOCK   = 32'h0FFFFFFF,
  parameter logic [31:0] CTRL_UNLOCK = 32'h007FFFFF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  avs_addr,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic [BURST_W-1:0] avs_burstcount,
  output logic [31:0]        avs_readdata,
  output logic               avs_readdatavalid,
  output logic               avs_waitrequest,
  input  logic               erase_req,
  input  logic [2:0]         erase_sector,
  output logic               op_busy,
  output logic               op_done,
  output logic               op_err,
  output logic [ADDR_W-1:0]  flash_data_addr,
  output logic               flash_data_read,
  output logic               flash_data_write,
  output logic [31:0]        flash_data_writedata,
  output logic [BURST_W-1:0] flash_data_burstcount,
  input  logic [31:0]        flash_data_readdata,
  input  logic               flash_data_waitrequest,
  input  logic               flash_data_readdatavalid,
  output logic               flash_csr_addr,
  output logic               flash_csr_read,
  output logic               flash_csr_write,
  output logic [31:0]        flash_csr_writedata,
  input  logic [31:0]        flash_csr_readdata
);

  localparam int OW = BURST_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_UNLOCK, S_PROG, S_ERASE, S_POLL, S_CHECK, S_LOCK, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                run_q;
  logic [OW-1:0]       outst;
  logic                erase_pend;
  logic [2:0]          sec_q;
  logic                is_wr;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;
  logic                poll_ph;
  logic                armed;
  logic [23:0]         tcnt;
  logic                ok_q;
  logic                err_q;

  logic                hold, idle_free, erase_go, write_go, sec_ok;
  logic [2:0]          go_sec;
  logic                rd_fire, st_busy, poll_eval, poll_fin, tmo;
  logic [OW-1:0]       add, sub;
  logic                unused_bits;

  assign unused_bits = &{1'b0, flash_csr_readdata[31:5], flash_csr_readdata[2]};

  // Any pending sequence request blocks new host reads in IDLE.
  assign hold      = avs_write | erase_req | erase_pend;
  assign idle_free = run_q && (state == S_IDLE) && (outst == '0);
  assign erase_go  = idle_free && (erase_req || erase_pend);
  assign write_go  = idle_free && avs_write && !(erase_req || erase_pend);
  assign go_sec    = erase_req ? erase_sector : sec_q;
  assign sec_ok    = (go_sec >= 3'd1) && (go_sec <= 3'd5);

  assign rd_fire   = flash_data_read && !flash_data_waitrequest;
  assign add       = !rd_fire ? '0 :
                     (avs_burstcount == '0) ? OW'(1) : OW'(avs_burstcount);
  assign sub       = (flash_data_readdatavalid && outst != '0) ? OW'(1) : '0;

  // Status is sampled on the odd poll phase, one cycle after the read.
  assign st_busy   = flash_csr_readdata[1:0] != 2'b00;
  assign poll_eval = (state == S_POLL) && poll_ph;
  assign poll_fin  = poll_eval && !st_busy && armed;
  assign tmo       = (state == S_POLL) && (tcnt == 24'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      run_q      <= 1'b0;
      outst      <= '0;
      erase_pend <= 1'b0;
      sec_q      <= 3'd0;
      is_wr      <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      poll_ph    <= 1'b0;
      armed      <= 1'b0;
      tcnt       <= 24'd0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      outst <= outst + add - sub;

      if (erase_go) begin
        erase_pend <= 1'b0;
        sec_q      <= go_sec;
      end else if (erase_req && run_q && (state == S_IDLE || state == S_DONE)) begin
        erase_pend <= 1'b1;
        sec_q      <= erase_sector;
      end

      if (erase_go || write_go) begin
        is_wr <= write_go;
        err_q <= erase_go && !sec_ok;
      end
      if (write_go) begin
        addr_q <= avs_addr;
        data_q <= avs_writedata;
      end

      if (state != S_POLL && state_nxt == S_POLL) begin
        poll_ph <= 1'b0;
        armed   <= 1'b0;
        tcnt    <= TIMEOUT_CYC - 24'd1;
      end else if (state == S_POLL) begin
        poll_ph <= ~poll_ph;
        if (tcnt != 24'd0) tcnt <= tcnt - 24'd1;
        if (poll_eval && st_busy) armed <= 1'b1;
        if (poll_fin) ok_q <= is_wr ? flash_csr_readdata[3] : flash_csr_readdata[4];
        else if (tmo) err_q <= 1'b1;
      end

      if (state == S_CHECK) err_q <= !ok_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (erase_go)      state_nxt = sec_ok ? S_UNLOCK : S_DONE;
        else if (write_go) state_nxt = S_UNLOCK;
      end
      S_UNLOCK: state_nxt = is_wr ? S_PROG : S_ERASE;
      S_PROG:   if (!flash_data_waitrequest) state_nxt = S_POLL;
      S_ERASE:  state_nxt = S_POLL;
      S_POLL: begin
        if (poll_fin) state_nxt = S_CHECK;
        else if (tmo) state_nxt = S_LOCK;
      end
      S_CHECK:  state_nxt = S_LOCK;
      S_LOCK:   state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    avs_waitrequest       = 1'b1;
    avs_readdata          = 32'd0;
    avs_readdatavalid     = 1'b0;
    op_busy               = 1'b0;
    op_done               = 1'b0;
    op_err                = 1'b0;
    flash_data_addr       = '0;
    flash_data_read       = 1'b0;
    flash_data_write      = 1'b0;
    flash_data_writedata  = 32'd0;
    flash_data_burstcount = '0;
    flash_csr_addr        = 1'b0;
    flash_csr_read        = 1'b0;
    flash_csr_write       = 1'b0;
    flash_csr_writedata   = 32'd0;
    // run_q keeps every output at its reset value until the first clock
    // after reset release, including the combinational pass-through paths.
    if (run_q) begin
      avs_readdata      = flash_data_readdata;
      avs_readdatavalid = flash_data_readdatavalid;
      case (state)
        S_IDLE: begin
          flash_data_addr       = avs_addr;
          flash_data_burstcount = avs_burstcount;
          flash_data_read       = avs_read && !hold;
          avs_waitrequest       = hold ? 1'b1 : flash_data_waitrequest;
        end
        S_UNLOCK: begin
          op_busy             = 1'b1;
          flash_csr_write     = 1'b1;
          flash_csr_addr      = 1'b1;
          flash_csr_writedata = CTRL_UNLOCK;
        end
        S_PROG: begin
          op_busy               = 1'b1;
          flash_data_write      = 1'b1;
          flash_data_addr       = addr_q;
          flash_data_writedata  = data_q;
          flash_data_burstcount = BURST_W'(1);
        end
        S_ERASE: begin
          op_busy             = 1'b1;
          flash_csr_write     = 1'b1;
          flash_csr_addr      = 1'b1;
          flash_csr_writedata = (CTRL_UNLOCK & ~32'h0070_0000) | {9'd0, sec_q, 20'd0};
        end
        S_POLL: begin
          op_busy        = 1'b1;
          flash_csr_read = !poll_ph;
        end
        S_CHECK: op_busy = 1'b1;
        S_LOCK: begin
          op_busy             = 1'b1;
          flash_csr_write     = 1'b1;
          flash_csr_addr      = 1'b1;
          flash_csr_writedata = CTRL_LOCK;
        end
        S_DONE: begin
          op_done         = 1'b1;
          op_err          = err_q;
          // Only a program sequence owns the stalled host write; after an
          // erase the write stays stalled and starts from IDLE.
          avs_waitrequest = !is_wr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oc_flash_ctrl.sv
module tb_oc_flash_ctrl;
  localparam logic [31:0] LOCK   = 32'h0FFFFFFF;
  localparam logic [31:0] UNLOCK = 32'h007FFFFF;
  localparam logic [2:0] K_RDREQ = 3'd0, K_RDV = 3'd1, K_CSRW = 3'd2,
                         K_DWR = 3'd3, K_DONE = 3'd4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] avs_addr = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [1:0]  avs_burstcount = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic        erase_req = 1'b0;
  logic [2:0]  erase_sector = '0;
  logic        op_busy, op_done, op_err;
  logic [15:0] flash_data_addr;
  logic        flash_data_read, flash_data_write;
  logic [31:0] flash_data_writedata;
  logic [1:0]  flash_data_burstcount;
  logic [31:0] flash_data_readdata = '0;
  logic        flash_data_waitrequest;
  logic        flash_data_readdatavalid = 1'b0;
  logic        flash_csr_addr, flash_csr_read, flash_csr_write;
  logic [31:0] flash_csr_writedata;
  logic [31:0] flash_csr_readdata = '0;

  always #5 clock = ~clock;

  oc_flash_ctrl #(
    .ADDR_W(16), .BURST_W(2), .TIMEOUT_CYC(24'd100),
    .CTRL_LOCK(LOCK), .CTRL_UNLOCK(UNLOCK)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .avs_addr(avs_addr), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_burstcount(avs_burstcount),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest),
    .erase_req(erase_req), .erase_sector(erase_sector),
    .op_busy(op_busy), .op_done(op_done), .op_err(op_err),
    .flash_data_addr(flash_data_addr), .flash_data_read(flash_data_read),
    .flash_data_write(flash_data_write), .flash_data_writedata(flash_data_writedata),
    .flash_data_burstcount(flash_data_burstcount),
    .flash_data_readdata(flash_data_readdata),
    .flash_data_waitrequest(flash_data_waitrequest),
    .flash_data_readdatavalid(flash_data_readdatavalid),
    .flash_csr_addr(flash_csr_addr), .flash_csr_read(flash_csr_read),
    .flash_csr_write(flash_csr_write), .flash_csr_writedata(flash_csr_writedata),
    .flash_csr_readdata(flash_csr_readdata)
  );

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic void push(input logic [2:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endfunction

  // ---------------- flash model ----------------
  logic [31:0] stat_q[$];
  logic [31:0] beat_q[$];
  int          lat = 0;
  int          nb;
  logic        wr_seen = 1'b0;

  // One stall cycle on every program write.
  assign flash_data_waitrequest = flash_data_write && !wr_seen;

  always @(posedge clock) begin
    wr_seen <= flash_data_write;
    if (flash_csr_read && !flash_csr_addr) begin
      if (stat_q.size() > 1)       flash_csr_readdata <= stat_q.pop_front();
      else if (stat_q.size() == 1) flash_csr_readdata <= stat_q[0];
    end
    flash_data_readdatavalid <= 1'b0;
    if (beat_q.size() > 0) begin
      if (lat > 0) lat <= lat - 1;
      else begin
        flash_data_readdatavalid <= 1'b1;
        flash_data_readdata      <= beat_q.pop_front();
      end
    end
    if (flash_data_read && !flash_data_waitrequest) begin
      nb = (flash_data_burstcount == 2'd0) ? 1 : int'(flash_data_burstcount);
      for (int i = 0; i < nb; i++) beat_q.push_back(32'hD000_0000 + {16'h0, flash_data_addr} + i);
      lat <= 3;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic see(input logic [2:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d a %h d %h, required none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event_kind%0d", e.kind), {k, a, d}, {e.kind, e.a, e.d});
    end
  endtask

  always @(negedge clock) begin
    if (flash_data_read && !flash_data_waitrequest)
      see(K_RDREQ, {16'h0, flash_data_addr}, {30'h0, flash_data_burstcount});
    if (avs_readdatavalid) see(K_RDV, 32'h0, avs_readdata);
    if (flash_csr_write) see(K_CSRW, {31'h0, flash_csr_addr}, flash_csr_writedata);
    if (flash_data_write && !flash_data_waitrequest)
      see(K_DWR, {16'h0, flash_data_addr}, flash_data_writedata);
    if (op_done) see(K_DONE, 32'h0, {31'h0, op_err});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_low(input int limit, input string name);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (!avs_waitrequest) begin ok = 1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 67'd1, 67'd0);
  endtask

  task automatic host_read(input logic [15:0] a, input logic [1:0] bc);
    int n = (bc == 2'd0) ? 1 : int'(bc);
    push(K_RDREQ, {16'h0, a}, {30'h0, bc});
    for (int i = 0; i < n; i++) push(K_RDV, 32'h0, 32'hD000_0000 + {16'h0, a} + i);
    avs_read = 1; avs_addr = a; avs_burstcount = bc;
    wait_low(20, "read_accept");
    @(posedge clock); #1;
    avs_read = 0;
  endtask

  // Host write, optionally with an erase request in the same cycle.
  task automatic host_write(input logic [15:0] a, input logic [31:0] d,
                            input bit with_erase, input logic [2:0] sec, input int limit);
    bit ok = 0;
    avs_write = 1; avs_addr = a; avs_writedata = d;
    if (with_erase) begin erase_req = 1; erase_sector = sec; end
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (!avs_waitrequest) begin ok = 1; break; end
      @(posedge clock); #1;
      erase_req = 0;
    end
    if (!ok) chk("write_complete_timeout", 67'd1, 67'd0);
    else begin
      chk("write_done_pulse", {66'd0, op_done}, 67'd1);
      chk("write_done_not_busy", {66'd0, op_busy}, 67'd0);
    end
    @(posedge clock); #1;
    avs_write = 0;
  endtask

  task automatic pulse_erase(input logic [2:0] sec);
    erase_req = 1; erase_sector = sec;
    tick();
    erase_req = 0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (op_done) begin cyc = i; break; end
    end
    if (cyc < 0) chk("op_done_timeout", 67'd1, 67'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  int cyc;

  initial begin
    // reset values, with host inputs active to prove the outputs are gated
    avs_read = 1; avs_addr = 16'h0055; avs_burstcount = 2'd2;
    #12;
    chk("rst_waitrequest", {66'd0, avs_waitrequest}, 67'd1);
    chk("rst_data_read",   {66'd0, flash_data_read}, 67'd0);
    chk("rst_data_addr",   {51'd0, flash_data_addr}, 67'd0);
    chk("rst_busy",        {66'd0, op_busy}, 67'd0);
    avs_read = 0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1;
    #1;
    chk("release_waitrequest_held", {66'd0, avs_waitrequest}, 67'd1);
    tick();
    chk("idle_waitrequest_follows_flash", {66'd0, avs_waitrequest}, 67'd0);

    // burst read pass-through, then burstcount 0 treated as a single beat
    host_read(16'h0010, 2'd2);
    repeat (8) tick();
    host_read(16'h0030, 2'd0);
    repeat (8) tick();

    // host program sequence
    stat_q = '{32'h2, 32'h2, 32'h8};
    push(K_CSRW, 32'h1, UNLOCK);
    push(K_DWR,  32'h1234, 32'hA5A5A5A5);
    push(K_CSRW, 32'h1, LOCK);
    push(K_DONE, 32'h0, 32'h0);
    host_write(16'h1234, 32'hA5A5A5A5, 0, 3'd0, 60);
    repeat (3) tick();

    // erase sector 3, erase_ok clear -> error, lock still written
    stat_q = '{32'h1, 32'h0};
    push(K_CSRW, 32'h1, UNLOCK);
    push(K_CSRW, 32'h1, 32'h003FFFFF);
    push(K_CSRW, 32'h1, LOCK);
    push(K_DONE, 32'h0, 32'h1);
    pulse_erase(3'd3);
    wait_done(40, cyc);
    repeat (3) tick();

    // status stuck busy: timeout after 100 poll cycles
    stat_q = '{32'h1};
    push(K_CSRW, 32'h1, UNLOCK);
    push(K_CSRW, 32'h1, 32'h002FFFFF);
    push(K_CSRW, 32'h1, LOCK);
    push(K_DONE, 32'h0, 32'h1);
    pulse_erase(3'd2);
    wait_done(130, cyc);
    chk("timeout_window", {66'd0, (cyc >= 100 && cyc <= 104)}, 67'd1);
    repeat (3) tick();

    // invalid sectors: immediate error, no flash access
    push(K_DONE, 32'h0, 32'h1);
    pulse_erase(3'd6);
    wait_done(3, cyc);
    chk("bad_sector6_latency", cyc, 1);
    push(K_DONE, 32'h0, 32'h1);
    pulse_erase(3'd0);
    wait_done(3, cyc);
    repeat (2) tick();

    // erase requested while a 2-beat read is in flight
    stat_q = '{32'h2, 32'h10};
    host_read(16'h0020, 2'd2);
    push(K_CSRW, 32'h1, UNLOCK);
    push(K_CSRW, 32'h1, 32'h001FFFFF);
    push(K_CSRW, 32'h1, LOCK);
    push(K_DONE, 32'h0, 32'h0);
    pulse_erase(3'd1);
    wait_done(60, cyc);
    repeat (3) tick();

    // same-cycle write and erase: erase first, then the write
    stat_q = '{32'h2, 32'h10, 32'h2, 32'h8};
    push(K_CSRW, 32'h1, UNLOCK);
    push(K_CSRW, 32'h1, 32'h004FFFFF);
    push(K_CSRW, 32'h1, LOCK);
    push(K_DONE, 32'h0, 32'h0);
    push(K_CSRW, 32'h1, UNLOCK);
    push(K_DWR,  32'h0ABC, 32'hCAFEF00D);
    push(K_CSRW, 32'h1, LOCK);
    push(K_DONE, 32'h0, 32'h0);
    host_write(16'h0ABC, 32'hCAFEF00D, 1, 3'd4, 200);
    repeat (3) tick();

    // reset while polling, then a normal write
    stat_q = '{32'h2};
    push(K_CSRW, 32'h1, UNLOCK);
    push(K_DWR,  32'h0077, 32'h55AA55AA);
    avs_write = 1; avs_addr = 16'h0077; avs_writedata = 32'h55AA55AA;
    repeat (12) tick();
    chk("mid_poll_busy", {66'd0, op_busy}, 67'd1);
    #2;
    reset_n = 0;
    #1;
    chk("async_rst_waitrequest", {66'd0, avs_waitrequest}, 67'd1);
    chk("async_rst_busy",        {66'd0, op_busy}, 67'd0);
    chk("async_rst_csr",         {65'd0, flash_csr_read, flash_csr_write}, 67'd0);
    chk("async_rst_data_addr",   {51'd0, flash_data_addr}, 67'd0);
    avs_write = 0;
    tick(); tick();
    reset_n = 1;
    tick();
    stat_q = '{32'h2, 32'h8};
    push(K_CSRW, 32'h1, UNLOCK);
    push(K_DWR,  32'h0042, 32'h11223344);
    push(K_CSRW, 32'h1, LOCK);
    push(K_DONE, 32'h0, 32'h0);
    host_write(16'h0042, 32'h11223344, 0, 3'd0, 60);
    repeat (5) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
